ether_tx: RTL

RMII transmit framer for the 50 MHz Ethernet path, the transmit counterpart of the dibit-level receive block. It accepts a payload as a ready/valid dibit stream and drives `txen`/`txd`. On the wire it produces preamble+SFD, the payload, zero padding up to the minimum frame size, the CRC-32 FCS, and then enforces the inter-packet gap. The input stream uses the same dibit ordering and valid semantics as the receiver's AXI output, so a transmit/receive loopback compares dibit-for-dibit.

---
 rtl/ether_pkg.sv | 29 ++
 rtl/crc32_dibit.sv | 22 ++
 rtl/ether_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII transmit/receive path.
// CRC helpers are reflected CRC-32, one wire bit per step, bit 0 first.
package ether_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_PAYLOAD,
      S_PAD,
      S_FCS,
      S_IPG
   } tx_state_t;

   localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0]  SFD_DIBIT      = 2'b11;

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   function automatic logic [31:0] crc_bit_step(input logic [31:0] c, input logic b);
      return (c >> 1) ^ ((c[0] ^ b) ? CRC_POLY_R : 32'h0);
   endfunction

   function automatic logic [31:0] crc_dibit_step(input logic [31:0] c, input logic [1:0] d);
      return crc_bit_step(crc_bit_step(c, d[0]), d[1]);
   endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Running CRC-32 register advanced one dibit per enabled cycle.
// Shared by the transmit framer and the receive-side FCS checker.
module crc32_dibit
   import ether_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        en,
   input  logic [1:0]  din,
   output logic [31:0] crc
);

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc_dibit_step(crc, din);
      end
   end

endmodule

// File: rtl/ether_tx.sv
// RMII transmit framer: preamble/SFD, payload, zero pad, FCS, inter-packet gap.
// state      | meaning
// IDLE       | line quiet, waiting for axiiv
// PREAMBLE   | 31 x 01 then SFD 11; ready during the SFD cycle
// PAYLOAD    | one accepted dibit per cycle; axiiv low aborts the frame
// PAD        | 00 dibits until payload+pad reaches MIN_DIBITS
// FCS        | 16 dibits of the complemented CRC, LSB first
// IPG        | txen low, input ignored, down-counter to IDLE
module ether_tx
   import ether_pkg::*;
#(
   parameter int IPG_CYCLES = 48,
   parameter int MIN_DIBITS = 240,
   parameter bit PAD_EN     = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       axiiv,
   input  logic [1:0] axiid,
   input  logic       axiilast,
   output logic       axiir,
   output logic       txen,
   output logic [1:0] txd,
   output logic       tx_err
);

   localparam int         IPG_W          = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES) : 1;
   localparam logic [7:0] MIN_LEN        = 8'(MIN_DIBITS);
   // The IDLE cycle before the next preamble completes the gap. After a
   // normal frame the first IPG cycle still carries the last FCS dibit;
   // after an abort txen is already low, so the countdown is one shorter.
   localparam logic [IPG_W-1:0] IPG_LOAD       = IPG_W'(IPG_CYCLES - 1);
   localparam logic [IPG_W-1:0] IPG_LOAD_ABORT = IPG_W'(IPG_CYCLES - 2);

   tx_state_t        state, state_nxt;
   logic [4:0]       pre_cnt, pre_cnt_nxt;
   logic [7:0]       len_cnt, len_cnt_nxt, len_inc;
   logic [3:0]       fcs_cnt, fcs_cnt_nxt;
   logic [IPG_W-1:0] ipg_cnt, ipg_cnt_nxt;
   logic             txen_nxt, tx_err_nxt;
   logic [1:0]       txd_nxt;
   logic             crc_clear, crc_en;
   logic [1:0]       crc_din;
   logic [31:0]      crc, crc_inv;

   assign axiir   = ((state == S_PREAMBLE) && (pre_cnt == 5'd31)) || (state == S_PAYLOAD);
   assign len_inc = (len_cnt == MIN_LEN) ? len_cnt : len_cnt + 8'd1;
   assign crc_inv = ~crc;

   crc32_dibit u_crc (
      .clk   (clk),
      .rst   (rst),
      .clear (crc_clear),
      .en    (crc_en),
      .din   (crc_din),
      .crc   (crc)
   );

   always_comb begin
      state_nxt   = state;
      pre_cnt_nxt = pre_cnt;
      len_cnt_nxt = len_cnt;
      fcs_cnt_nxt = fcs_cnt;
      ipg_cnt_nxt = ipg_cnt;
      txen_nxt    = 1'b0;
      txd_nxt     = 2'b00;
      tx_err_nxt  = 1'b0;
      crc_clear   = 1'b0;
      crc_en      = 1'b0;
      crc_din     = 2'b00;

      case (state)
         S_IDLE: begin
            if (axiiv) begin
               state_nxt   = S_PREAMBLE;
               pre_cnt_nxt = 5'd0;
               len_cnt_nxt = 8'd0;
               txen_nxt    = 1'b1;
               txd_nxt     = PREAMBLE_DIBIT;
            end
         end

         S_PREAMBLE, S_PAYLOAD: begin
            if (!axiir) begin
               pre_cnt_nxt = pre_cnt + 5'd1;
               txen_nxt    = 1'b1;
               if (pre_cnt == 5'd30) begin
                  txd_nxt   = SFD_DIBIT;
                  crc_clear = 1'b1;
               end else begin
                  txd_nxt   = PREAMBLE_DIBIT;
               end
            end else if (axiiv) begin
               txen_nxt    = 1'b1;
               txd_nxt     = axiid;
               crc_en      = 1'b1;
               crc_din     = axiid;
               len_cnt_nxt = len_inc;
               state_nxt   = S_PAYLOAD;
               if (axiilast) begin
                  fcs_cnt_nxt = 4'd0;
                  state_nxt   = (PAD_EN && (len_inc < MIN_LEN)) ? S_PAD : S_FCS;
               end
            end else begin
               tx_err_nxt  = 1'b1;
               ipg_cnt_nxt = IPG_LOAD_ABORT;
               state_nxt   = S_IPG;
            end
         end

         S_PAD: begin
            txen_nxt    = 1'b1;
            crc_en      = 1'b1;
            len_cnt_nxt = len_inc;
            if (len_inc == MIN_LEN) begin
               state_nxt = S_FCS;
            end
         end

         S_FCS: begin
            txen_nxt    = 1'b1;
            txd_nxt     = crc_inv[{fcs_cnt, 1'b0} +: 2];
            fcs_cnt_nxt = fcs_cnt + 4'd1;
            if (fcs_cnt == 4'd15) begin
               ipg_cnt_nxt = IPG_LOAD;
               state_nxt   = S_IPG;
            end
         end

         S_IPG: begin
            if (ipg_cnt == '0) begin
               state_nxt = S_IDLE;
            end else begin
               ipg_cnt_nxt = ipg_cnt - 1'b1;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         pre_cnt <= '0;
         len_cnt <= '0;
         fcs_cnt <= '0;
         ipg_cnt <= '0;
         txen    <= 1'b0;
         txd     <= 2'b00;
         tx_err  <= 1'b0;
      end else begin
         state   <= state_nxt;
         pre_cnt <= pre_cnt_nxt;
         len_cnt <= len_cnt_nxt;
         fcs_cnt <= fcs_cnt_nxt;
         ipg_cnt <= ipg_cnt_nxt;
         txen    <= txen_nxt;
         txd     <= txd_nxt;
         tx_err  <= tx_err_nxt;
      end
   end

endmodule
